// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Purpose  : Shared definitions for the action round-robin scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package sched_pkg;

    typedef enum logic [1:0] {
        S_ARB    = 2'd0,
        S_ACCEPT = 2'd1,
        S_ISSUE  = 2'd2,
        S_GAP    = 2'd3
    } sched_state_e;

    // Field layout of the action word; the scheduler never decodes these.
    localparam int PKTID_MSB    = 31;
    localparam int PKTID_LSB    = 24;
    localparam int DISC_BIT_LSB = 16;
    localparam int RULE_LSB     = 0;

    localparam int DEF_CREDITS  = 16;

endpackage : sched_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational rotate-priority encoder; ptr has highest priority.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    // Walk from the farthest slot back toward ptr so the nearest hit wins.
    always_comb begin
        int w_idx;
        gnt_any = |req;
        gnt_idx = '0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (req[w_idx[PTR_W-1:0]]) begin
                gnt_idx = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/action_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : action_rr_sched
//  Purpose  : Credit-controlled round-robin scheduler feeding transmit actions.
//  Revision : 1.0  initial release
// ============================================================================
module action_rr_sched
    import sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ACT_W   = 32,
    parameter int CREDITS = DEF_CREDITS,
    parameter int CRED_W  = 5,
    parameter int MIN_GAP = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sched_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ACT_W-1:0] req_action,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     action_valid,
    output logic [ACT_W-1:0]         action,
    input  logic                     pktIDout_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic [CRED_W-1:0]        credit_cnt,
    output logic                     cred_ovf
);

    localparam logic [1:0] c_ARB    = S_ARB;
    localparam logic [1:0] c_ACCEPT = S_ACCEPT;
    localparam logic [1:0] c_ISSUE  = S_ISSUE;
    localparam logic [1:0] c_GAP    = S_GAP;

    localparam logic [CRED_W-1:0] c_CRED_MAX = CRED_W'(CREDITS);
    localparam logic [ID_W-1:0]   c_LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [2:0]       r_gap_cnt;

    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_gnt_any;
    logic             w_arb_go;
    logic             w_issue;
    logic [ACT_W-1:0] w_act [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_act[gi] = req_action[gi*ACT_W +: ACT_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_arb_go = sched_en && (credit_cnt != '0) && w_gnt_any;
    assign w_issue  = (r_state == c_ISSUE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ARB;
            r_rr_ptr     <= '0;
            r_gap_cnt    <= '0;
            req_ready    <= '0;
            action_valid <= 1'b0;
            action       <= '0;
            grant_id     <= '0;
        end else begin
            action_valid <= 1'b0;
            case (r_state)
                c_ARB: begin
                    if (w_arb_go) begin
                        req_ready <= NUM_REQ'(1) << w_gnt_idx;
                        grant_id  <= w_gnt_idx;
                        r_state   <= c_ACCEPT;
                    end
                end
                c_ACCEPT: begin
                    req_ready <= '0;
                    if (req_valid[grant_id]) begin
                        action       <= w_act[grant_id];
                        action_valid <= 1'b1;
                        r_rr_ptr     <= (grant_id == c_LAST_ID) ? '0 : grant_id + 1'b1;
                        r_state      <= c_ISSUE;
                    end else begin
                        r_state      <= c_ARB;
                    end
                end
                c_ISSUE: begin
                    if (MIN_GAP > 0) begin
                        r_gap_cnt <= 3'(MIN_GAP - 1);
                        r_state   <= c_GAP;
                    end else begin
                        r_state   <= c_ARB;
                    end
                end
                default: begin
                    if (r_gap_cnt == '0) begin
                        r_state   <= c_ARB;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Issue and return in the same cycle cancel; a surplus return is flagged, not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_cnt <= c_CRED_MAX;
            cred_ovf   <= 1'b0;
        end else begin
            if (w_issue && !pktIDout_valid) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!w_issue && pktIDout_valid) begin
                if (credit_cnt == c_CRED_MAX) begin
                    cred_ovf   <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
            end
        end
    end

endmodule : action_rr_sched
`default_nettype wire

// File: tb/tb_action_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_action_rr_sched
//  Purpose  : Directed self-checking bench for action_rr_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_action_rr_sched;

    localparam int NUM_REQ = 4;
    localparam int ACT_W   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     sched_en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*ACT_W-1:0] req_action;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     action_valid;
    logic [ACT_W-1:0]         action;
    logic                     pktIDout_valid;
    logic [1:0]               grant_id;
    logic [4:0]               credit_cnt;
    logic                     cred_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    action_rr_sched #(
        .NUM_REQ (NUM_REQ),
        .ACT_W   (ACT_W),
        .CREDITS (16),
        .CRED_W  (5),
        .MIN_GAP (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sched_en       (sched_en),
        .req_valid      (req_valid),
        .req_action     (req_action),
        .req_ready      (req_ready),
        .action_valid   (action_valid),
        .action         (action),
        .pktIDout_valid (pktIDout_valid),
        .grant_id       (grant_id),
        .credit_cnt     (credit_cnt),
        .cred_ovf       (cred_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_av(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!action_valid && n < 20);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'h0);
        chk({tag, ".av"},    32'(action_valid), 32'h0);
        chk({tag, ".act"},   action, 32'h0);
        chk({tag, ".gid"},   32'(grant_id), 32'h0);
        chk({tag, ".cred"},  32'(credit_cnt), 32'd16);
        chk({tag, ".ovf"},   32'(cred_ovf), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_vals("rst");
        step();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int cnt;
        logic bad;

        reset = 1'b0; sched_en = 1'b0; req_valid = '0; req_action = '0; pktIDout_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_action[i*ACT_W +: ACT_W] = 32'hA000_0000 | i;
        step(); step();
        do_reset();

        // T1: single requester, basic latency and credit decrement
        req_action[0 +: ACT_W] = 32'h0500_0003;
        req_valid = 4'b0001; sched_en = 1'b1;
        step();
        chk("t1.ready", 32'(req_ready), 32'h1);
        chk("t1.av_lo", 32'(action_valid), 32'h0);
        step();
        chk("t1.av", 32'(action_valid), 32'h1);
        chk("t1.act", action, 32'h0500_0003);
        chk("t1.gid", 32'(grant_id), 32'h0);
        chk("t1.ready_lo", 32'(req_ready), 32'h0);
        req_valid = '0;
        step();
        chk("t1.av_pulse", 32'(action_valid), 32'h0);
        chk("t1.cred", 32'(credit_cnt), 32'd15);
        step(); step();

        // T2: all requesters busy, rotation 0,1,2,3,0.. at one issue per 4 cycles
        req_action[0 +: ACT_W] = 32'hA000_0000;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_av(n);
            chk($sformatf("t2.gap%0d", k), 32'(n), (k == 0) ? 32'd2 : 32'd4);
            chk($sformatf("t2.gid%0d", k), 32'(grant_id), 32'(k % 4));
            chk($sformatf("t2.act%0d", k), action, 32'hA000_0000 | 32'(k % 4));
        end
        req_valid = '0;
        step();
        chk("t2.cred", 32'(credit_cnt), 32'd8);
        step(); step();

        // T3: credit exhaustion then a single return
        do_reset();
        req_valid = 4'b0001;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            wait_av(n);
            if (action_valid) cnt++;
        end
        chk("t3.issues", 32'(cnt), 32'd16);
        step();
        chk("t3.cred0", 32'(credit_cnt), 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (req_ready != '0 || action_valid) bad = 1'b1;
        end
        chk("t3.stall", 32'(bad), 32'h0);
        pktIDout_valid = 1'b1;
        step();
        pktIDout_valid = 1'b0;
        chk("t3.cred1", 32'(credit_cnt), 32'd1);
        wait_av(n);
        chk("t3.reissue", 32'(n), 32'd2);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (action_valid) cnt++;
        end
        chk("t3.extra", 32'(cnt), 32'd0);
        chk("t3.cred_end", 32'(credit_cnt), 32'd0);

        // T4: issue coincident with a return at count 7
        req_valid = '0;
        pktIDout_valid = 1'b1;
        for (int k = 0; k < 7; k++) step();
        pktIDout_valid = 1'b0;
        chk("t4.cred7", 32'(credit_cnt), 32'd7);
        req_valid = 4'b0001;
        step(); step();
        chk("t4.av", 32'(action_valid), 32'h1);
        pktIDout_valid = 1'b1; req_valid = '0;
        step();
        pktIDout_valid = 1'b0;
        chk("t4.cred_same", 32'(credit_cnt), 32'd7);
        step(); step();

        // T5: surplus return at full credit
        do_reset();
        pktIDout_valid = 1'b1;
        step();
        pktIDout_valid = 1'b0;
        chk("t5.cred", 32'(credit_cnt), 32'd16);
        chk("t5.ovf", 32'(cred_ovf), 32'h1);
        for (int k = 0; k < 5; k++) step();
        chk("t5.ovf_sticky", 32'(cred_ovf), 32'h1);
        do_reset();
        chk("t5.ovf_clr", 32'(cred_ovf), 32'h0);

        // T6: requester withdraws during ACCEPT; pointer must not advance
        req_valid = 4'b0010;
        step();
        chk("t6.ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (action_valid || req_ready != '0) bad = 1'b1;
        end
        chk("t6.no_issue", 32'(bad), 32'h0);
        chk("t6.cred", 32'(credit_cnt), 32'd16);
        req_valid = 4'b1010;
        wait_av(n);
        chk("t6.lat", 32'(n), 32'd2);
        chk("t6.gid", 32'(grant_id), 32'h1);
        chk("t6.act", action, 32'hA000_0001);
        req_valid = '0;
        step(); step(); step();

        // T6b: asynchronous reset during ISSUE
        req_valid = 4'b0100;
        wait_av(n);
        chk("t6b.av", 32'(action_valid), 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_vals("t6b");
        req_valid = '0;
        step();
        reset = 1'b1;
        step();
        chk("t6b.idle", 32'(action_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_action_rr_sched
`default_nettype wire
